inverse_lifting: RTL and testbench
==================================

# inverse_lifting

Inverse 5/3 integer lifting stage that reconstructs the original sample stream from coarse (approximation) and detail coefficient pairs. It sits at the decoder end of the DWT chain and undoes the forward update step, then the forward predict step. It emits reconstructed samples one per handshake, interleaved as even, odd, even, odd. Frame boundaries are carried by `in_last` / `out_last`, and the block applies symmetric extension at both frame edges.

## Interface
- `W`, default 8: coefficient and sample width. All arithmetic wraps modulo 2^W.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `coarse_in`  in  W: coarse coefficient s[n].
- `detail_in`  in  W: detail coefficient d[n].
- `in_valid`  in  1: the pair {s[n], d[n]} is presented.
- `in_last`  in  1: the pair is the final pair of the frame. Qualified by `in_valid`.
- `in_ready`  out  1: the block accepts the pair this cycle.
- `sample_out`  out  W: reconstructed sample.
- `out_valid`  out  1: `sample_out` is valid.
- `out_last`  out  1: final sample of the frame. Asserted only with `out_valid`.
- `out_ready`  in  1: the downstream consumer accepts the sample.

## Operation
- A pair is accepted when `in_valid && in_ready`. A sample is transferred when `out_valid && out_ready`.
- Undo update: even[n] = s[n] − ((d[n−1] + d[n]) >> 2).
  - The sum is computed in W+1 bits, shifted, then truncated to W bits.
  - The subtraction wraps mod 2^W.
  - For n = 0, d[−1] = d[0].
- Undo predict: odd[n] = d[n] + ((even[n] + even[n+1]) >> 1).
  - The sum is computed in W+1 bits; the addition wraps mod 2^W.
  - For the last pair, even[n+1] = even[n], which gives odd = d + even.
- Registers:
  - `e_prev` and `d_prev` hold the previous pair's even sample and detail coefficient.
  - `ob_e` and `ob_o` form the output buffer.
  - `tail_e` and `tail_o` hold the final pair of a multi-pair frame.
  - `tail_pend` flags that the tail samples are waiting to be emitted.
- FSM states: IDLE, HOLD, EMIT_E, EMIT_O, TAIL_E, TAIL_O.
- `in_ready` = 1 only in IDLE and HOLD.
- IDLE: on accept, compute even[0] and latch it into `e_prev`, with `d_prev` = d[0].
  - If `in_last`, load `tail_e` = even[0] and `tail_o` = d[0] + even[0], then go to TAIL_E.
  - Otherwise go to HOLD.
- HOLD: on accept, compute even[n] and load `ob_e` = `e_prev`, `ob_o` = odd[n−1]. Then latch `e_prev` = even[n] and `d_prev` = d[n].
  - If `in_last`, load `tail_e` = even[n], `tail_o` = d[n] + even[n], and set `tail_pend`.
  - Go to EMIT_E.
- EMIT_E: drive `ob_e`. On transfer, go to EMIT_O.
- EMIT_O: drive `ob_o`. On transfer:
  - if `tail_pend`, clear it and go to TAIL_E;
  - otherwise go to HOLD.
- TAIL_E: drive `tail_e`. On transfer, go to TAIL_O.
- TAIL_O: drive `tail_o` with `out_last` = 1. On transfer, go to IDLE; the next frame restarts with the n = 0 extension.
- `out_valid` = 1 in EMIT_E, EMIT_O, TAIL_E and TAIL_O, and 0 otherwise.
- `sample_out` holds its value while `out_valid && !out_ready`; no drop and no duplicate.
- Reset mid-frame: the partial frame is discarded. No `out_last` is emitted for it.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready` = 1 on the first cycle after reset;
  - `sample_out` = 0, `out_valid` = 0, `out_last` = 0;
  - all internal registers = 0, `tail_pend` = 0.
- All outputs except `in_ready` are registered. `in_ready` decodes from state only and never depends on `out_ready` combinationally.
- Pair 0 produces no output. Pair n ≥ 1 accepted at cycle t puts even[n−1] on the output at cycle t+1.
- With `out_ready` held high:
  - steady-state throughput is one pair per 3 cycles (accept, even, odd);
  - a single-pair frame takes 3 cycles from accept to the `out_last` transfer.
- `out_ready` low stalls the FSM in the current EMIT or TAIL state indefinitely. `in_ready` stays 0 throughout.
- `in_valid` while `in_ready` = 0 is ignored. Upstream must hold the pair.

## Test plan
- Single-pair frame s=10, d=3, `in_last`=1, `out_ready`=1: outputs 9 then 12, `out_last` on 12, back to IDLE with `in_ready`=1.
- Two-pair frame (s=20, d=4), then (s=30, d=8, last): outputs 18, 26, 27, 35; `out_last` only on 35.
- Wrap case, single pair s=1, d=200, last: outputs 157 then 101. Checks the W+1-bit sums and mod-256 wrap.
- Backpressure: repeat the two-pair frame with `out_ready` toggling 1,0,0,1,…: same 4 samples in order, `sample_out` stable while stalled, `in_ready`=0 during EMIT and TAIL.
- Back-to-back frames: the two-pair frame immediately followed by the single-pair frame (10, 3): output 18, 26, 27, 35(last), 9, 12(last). The second frame's even[0] uses d[−1] = d[0], not the previous frame's d.
- Reset mid-frame: accept (20, 4), assert `rst` for 1 cycle, then send the (10, 3, last) frame: no output from the aborted frame; outputs 9, 12(last); all outputs are 0 during reset.

Source files
------------

// File: rtl/inverse_lifting.sv
`default_nettype none
// ============================================================================
// inverse_lifting : inverse 5/3 lifting stage, (coarse, detail) pairs in,
// interleaved even/odd samples out with symmetric extension at frame edges.
// Revision 1.0
// ============================================================================
module inverse_lifting #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] coarse_in,
  input  logic [W-1:0] detail_in,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] sample_out,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    EMIT_E = 3'd2,
    EMIT_O = 3'd3,
    TAIL_E = 3'd4,
    TAIL_O = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] e_prev_q, e_prev_d;
  logic [W-1:0] d_prev_q, d_prev_d;
  logic [W-1:0] ob_e_q, ob_e_d;
  logic [W-1:0] ob_o_q, ob_o_d;
  logic [W-1:0] tail_e_q, tail_e_d;
  logic [W-1:0] tail_o_q, tail_o_d;
  logic         tail_pend_q, tail_pend_d;
  logic [W-1:0] sample_out_q, sample_out_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;

  logic         w_accept;
  logic [W-1:0] w_d_left;
  logic [W:0]   w_dsum;
  logic [W:0]   w_dsum_sh;
  logic [W-1:0] w_even;
  logic [W:0]   w_esum;
  logic [W:0]   w_esum_sh;
  logic [W-1:0] w_odd_prev;
  logic [W-1:0] w_tail_odd;

  assign in_ready   = (state_q == IDLE) || (state_q == HOLD);
  assign w_accept   = in_valid && in_ready;

  // The first pair of a frame mirrors its own detail as d[-1].
  assign w_d_left   = (state_q == IDLE) ? detail_in : d_prev_q;
  assign w_dsum     = {1'b0, w_d_left} + {1'b0, detail_in};
  assign w_dsum_sh  = w_dsum >> 2;
  assign w_even     = coarse_in - w_dsum_sh[W-1:0];

  assign w_esum     = {1'b0, e_prev_q} + {1'b0, w_even};
  assign w_esum_sh  = w_esum >> 1;
  assign w_odd_prev = d_prev_q + w_esum_sh[W-1:0];
  assign w_tail_odd = detail_in + w_even;

  always_comb begin
    state_d      = state_q;
    e_prev_d     = e_prev_q;
    d_prev_d     = d_prev_q;
    ob_e_d       = ob_e_q;
    ob_o_d       = ob_o_q;
    tail_e_d     = tail_e_q;
    tail_o_d     = tail_o_q;
    tail_pend_d  = tail_pend_q;
    sample_out_d = sample_out_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          e_prev_d = w_even;
          d_prev_d = detail_in;
          if (in_last) begin
            tail_e_d     = w_even;
            tail_o_d     = w_tail_odd;
            state_d      = TAIL_E;
            sample_out_d = w_even;
            out_valid_d  = 1'b1;
            out_last_d   = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (w_accept) begin
          ob_e_d   = e_prev_q;
          ob_o_d   = w_odd_prev;
          e_prev_d = w_even;
          d_prev_d = detail_in;
          if (in_last) begin
            tail_e_d    = w_even;
            tail_o_d    = w_tail_odd;
            tail_pend_d = 1'b1;
          end
          state_d      = EMIT_E;
          sample_out_d = e_prev_q;
          out_valid_d  = 1'b1;
          out_last_d   = 1'b0;
        end
      end

      EMIT_E: begin
        if (out_ready) begin
          state_d      = EMIT_O;
          sample_out_d = ob_o_q;
        end
      end

      EMIT_O: begin
        if (out_ready) begin
          if (tail_pend_q) begin
            tail_pend_d  = 1'b0;
            state_d      = TAIL_E;
            sample_out_d = tail_e_q;
          end else begin
            state_d     = HOLD;
            out_valid_d = 1'b0;
          end
        end
      end

      TAIL_E: begin
        if (out_ready) begin
          state_d      = TAIL_O;
          sample_out_d = tail_o_q;
          out_last_d   = 1'b1;
        end
      end

      TAIL_O: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      e_prev_q     <= '0;
      d_prev_q     <= '0;
      ob_e_q       <= '0;
      ob_o_q       <= '0;
      tail_e_q     <= '0;
      tail_o_q     <= '0;
      tail_pend_q  <= 1'b0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      e_prev_q     <= e_prev_d;
      d_prev_q     <= d_prev_d;
      ob_e_q       <= ob_e_d;
      ob_o_q       <= ob_o_d;
      tail_e_q     <= tail_e_d;
      tail_o_q     <= tail_o_d;
      tail_pend_q  <= tail_pend_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_inverse_lifting.sv
`default_nettype none
// ============================================================================
// tb_inverse_lifting : directed vectors with hand-computed samples.
// Revision 1.0
// ============================================================================
module tb_inverse_lifting;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] coarse_in;
  logic [W-1:0] detail_in;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] sample_out;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  int checks = 0;
  int errors = 0;
  bit bp_en  = 1'b0;
  int bp_k   = 0;

  inverse_lifting #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .coarse_in  (coarse_in),
    .detail_in  (detail_in),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [W-1:0] s, input logic [W-1:0] d, input logic last);
    int  n;
    bit  done;
    n         = 0;
    done      = 1'b0;
    coarse_in = s;
    detail_in = d;
    in_last   = last;
    in_valid  = 1'b1;
    while (!done && n < 40) begin
      if (in_ready === 1'b1) done = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Checks value and stability of the pending sample until it transfers.
  task automatic expect_out(input string tag, input logic [W-1:0] exp, input logic exp_last);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      if (bp_en) begin
        out_ready = ((bp_k % 4) == 0) || ((bp_k % 4) == 3);
        bp_k++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid === 1'b1) begin
        chk({tag, "_data"}, {24'd0, sample_out}, {24'd0, exp});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, exp_last});
        chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
        if (out_ready) done = 1'b1;
      end
      tick();
      n++;
    end
    out_ready = 1'b1;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_oval"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    coarse_in = '0;
    detail_in = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_sample", {24'd0, sample_out}, 32'd0);
    chk("rst_oval", {31'd0, out_valid}, 32'd0);
    chk("rst_olast", {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_irdy", {31'd0, in_ready}, 32'd1);

    // Single pair: even = 10 - (6>>2) = 9, odd = 3 + 9 = 12.
    send_pair(8'd10, 8'd3, 1'b1);
    chk("single_lat", {31'd0, out_valid}, 32'd1);
    expect_out("single_e", 8'd9, 1'b0);
    expect_out("single_o", 8'd12, 1'b1);
    expect_idle("single_end");

    // Two pairs: even 18, 27; odd0 = 4 + (45>>1) = 26; odd1 = 8 + 27 = 35.
    send_pair(8'd20, 8'd4, 1'b0);
    chk("two_nooutput", {31'd0, out_valid}, 32'd0);
    send_pair(8'd30, 8'd8, 1'b1);
    chk("two_lat", {31'd0, out_valid}, 32'd1);
    expect_out("two_e0", 8'd18, 1'b0);
    expect_out("two_o0", 8'd26, 1'b0);
    expect_out("two_e1", 8'd27, 1'b0);
    expect_out("two_o1", 8'd35, 1'b1);
    expect_idle("two_end");

    // Wrap: even = 1 - (400>>2) = 157 (mod 256), odd = 200 + 157 = 101.
    send_pair(8'd1, 8'd200, 1'b1);
    expect_out("wrap_e", 8'd157, 1'b0);
    expect_out("wrap_o", 8'd101, 1'b1);
    expect_idle("wrap_end");

    // Backpressure with out_ready pattern 1,0,0,1,...
    bp_en = 1'b1;
    bp_k  = 1;
    send_pair(8'd20, 8'd4, 1'b0);
    send_pair(8'd30, 8'd8, 1'b1);
    expect_out("bp_e0", 8'd18, 1'b0);
    expect_out("bp_o0", 8'd26, 1'b0);
    expect_out("bp_e1", 8'd27, 1'b0);
    expect_out("bp_o1", 8'd35, 1'b1);
    bp_en = 1'b0;
    expect_idle("bp_end");

    // Back-to-back frames; second frame must re-apply d[-1] = d[0].
    send_pair(8'd20, 8'd4, 1'b0);
    send_pair(8'd30, 8'd8, 1'b1);
    expect_out("b2b_e0", 8'd18, 1'b0);
    expect_out("b2b_o0", 8'd26, 1'b0);
    expect_out("b2b_e1", 8'd27, 1'b0);
    expect_out("b2b_o1", 8'd35, 1'b1);
    send_pair(8'd10, 8'd3, 1'b1);
    expect_out("b2b_e2", 8'd9, 1'b0);
    expect_out("b2b_o2", 8'd12, 1'b1);
    expect_idle("b2b_end");

    // Reset mid-frame discards the partial frame.
    send_pair(8'd20, 8'd4, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_sample", {24'd0, sample_out}, 32'd0);
    chk("mid_rst_oval", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_olast", {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    chk("mid_rst_irdy", {31'd0, in_ready}, 32'd1);
    send_pair(8'd10, 8'd3, 1'b1);
    expect_out("mid_e", 8'd9, 1'b0);
    expect_out("mid_o", 8'd12, 1'b1);
    expect_idle("mid_end");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
